// File: rtl/ram_port_arbiter.sv
// Arbitrates the single synchronous data-RAM port between the cpu load/store path and
// the ext loader, with an ext burst lock and saturating per-port completion counters.
module ram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              start,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_lock,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner,
    output logic [CNT_W-1:0]  cpu_cnt,
    output logic [CNT_W-1:0]  ext_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                lock_q, lock_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                acc_we_q, acc_we_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ext_ack_q, ext_ack_d;
    logic [CNT_W-1:0]    cpu_cnt_q, cpu_cnt_d;
    logic [CNT_W-1:0]    ext_cnt_q, ext_cnt_d;
    logic                grant;
    logic                grant_ext;

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latch).
        state_d     = state_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        acc_we_d    = acc_we_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        cpu_cnt_d   = cpu_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        grant       = 1'b0;
        grant_ext   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A held lock survives only while ext keeps both lock and request up.
                lock_d = lock_q & ext_req & ext_lock;
                if (lock_d) begin
                    grant     = 1'b1;
                    grant_ext = 1'b1;
                end else if (cpu_req && ext_req) begin
                    grant     = 1'b1;
                    grant_ext = ~owner_q;
                end else if (cpu_req || ext_req) begin
                    grant     = 1'b1;
                    grant_ext = ext_req;
                end

                if (grant) begin
                    owner_d     = grant_ext;
                    ram_en_d    = 1'b1;
                    ram_we_d    = grant_ext ? ext_we : cpu_we;
                    ram_addr_d  = grant_ext ? ext_addr : cpu_addr;
                    ram_wdata_d = grant_ext ? ext_wdata : cpu_wdata;
                    acc_we_d    = ram_we_d;
                    lock_d      = grant_ext & ext_lock;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = RESP;
                if (owner_q) begin
                    ext_ack_d = 1'b1;
                    if (ext_cnt_q != '1) ext_cnt_d = ext_cnt_q + CNT_W'(1);
                end else begin
                    cpu_ack_d = 1'b1;
                    if (cpu_cnt_q != '1) cpu_cnt_d = cpu_cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1) begin
        if (start) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            lock_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            acc_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_cnt_q   <= '0;
            ext_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            acc_we_q    <= acc_we_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            cpu_cnt_q   <= cpu_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
        end
    end

    // RAM read data arrives during RESP, so it is steered straight through to the winner.
    assign cpu_rdata = (cpu_ack_q && !acc_we_q) ? ram_rdata : '0;
    assign ext_rdata = (ext_ack_q && !acc_we_q) ? ram_rdata : '0;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign cpu_cnt   = cpu_cnt_q;
    assign ext_cnt   = ext_cnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a transaction-level model predicts every output each cycle
// under directed scenarios and randomized requesters, with a small RAM behind the port.
module tb_ram_port_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 2;
    localparam int MEM_N   = 256;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk1 = 1'b0;
    logic              start;
    logic              cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [ADDR_W-1:0] cpu_addr, ext_addr;
    logic [DATA_W-1:0] cpu_wdata, ext_wdata;
    logic              cpu_ack, ext_ack;
    logic [DATA_W-1:0] cpu_rdata, ext_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy, owner;
    logic [CNT_W-1:0]  cpu_cnt, ext_cnt;
    logic              mem_load;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk1 = ~clk1;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .start(start),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_lock(ext_lock),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner),
        .cpu_cnt(cpu_cnt), .ext_cnt(ext_cnt)
    );

    function automatic logic [DATA_W-1:0] init_val(int i);
        case (i)
            3:       return 32'd14;
            4:       return 32'd45;
            5:       return 32'd23;
            default: return 32'(i) * 32'd3 + 32'd100;
        endcase
    endfunction

    // Single-port RAM with registered read, loaded once at the start of the run.
    logic [DATA_W-1:0] ram_mem [MEM_N];
    always @(posedge clk1) begin
        if (mem_load) begin
            for (int i = 0; i < MEM_N; i++) ram_mem[i] <= init_val(i);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr[7:0]];
        end
    end

    // Reference model: what the outputs must be after the next edge.
    int                m_phase;
    int                m_owner;
    bit                m_lock;
    int                m_cnt [2];
    bit                m_ack [2];
    bit                m_en, m_we, m_acc_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rd;
    logic [DATA_W-1:0] shadow [MEM_N];

    task automatic model_edge();
        int win;
        if (start) begin
            m_phase = 0; m_owner = 1; m_lock = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_ack[0] = 0; m_ack[1] = 0;
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            return;
        end
        case (m_phase)
            0: begin
                win = -1;
                if (m_lock && !(ext_req && ext_lock)) m_lock = 0;
                if (m_lock)                  win = 1;
                else if (cpu_req && ext_req) win = 1 - m_owner;
                else if (cpu_req)            win = 0;
                else if (ext_req)            win = 1;
                if (win >= 0) begin
                    m_owner  = win;
                    m_en     = 1;
                    m_we     = (win == 1) ? ext_we    : cpu_we;
                    m_addr   = (win == 1) ? ext_addr  : cpu_addr;
                    m_wdata  = (win == 1) ? ext_wdata : cpu_wdata;
                    m_acc_we = m_we;
                    if (m_we) shadow[m_addr[7:0]] = m_wdata;
                    else      m_rd = shadow[m_addr[7:0]];
                    m_lock  = (win == 1) && ext_lock;
                    m_phase = 1;
                end
            end
            1: begin
                m_en = 0; m_we = 0;
                m_ack[m_owner] = 1;
                if (m_cnt[m_owner] < CNT_MAX) m_cnt[m_owner]++;
                m_phase = 2;
            end
            default: begin
                m_ack[0] = 0; m_ack[1] = 0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy", busy, m_phase != 0);
        check("ram_en", ram_en, m_en);
        check("ram_we", ram_we, m_we);
        check("ram_addr", ram_addr, m_addr);
        check("ram_wdata", ram_wdata, m_wdata);
        check("cpu_ack", cpu_ack, m_ack[0]);
        check("ext_ack", ext_ack, m_ack[1]);
        check("owner", owner, m_owner[0]);
        check("cpu_cnt", cpu_cnt, m_cnt[0]);
        check("ext_cnt", ext_cnt, m_cnt[1]);
        if (m_ack[0]) begin
            check("cpu_rdata", cpu_rdata, m_acc_we ? 32'd0 : m_rd);
            check("ext_rdata_nonowner", ext_rdata, 32'd0);
        end
        if (m_ack[1]) begin
            check("ext_rdata", ext_rdata, m_acc_we ? 32'd0 : m_rd);
            check("cpu_rdata_nonowner", cpu_rdata, 32'd0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk1);
        @(negedge clk1);
        mem_load = 1'b0;
        compare_all();
    endtask

    // Let each requester finish its outstanding access, dropping req on its own ack.
    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (m_ack[0]) cpu_req = 1'b0;
            if (m_ack[1]) begin ext_req = 1'b0; ext_lock = 1'b0; end
            if (!cpu_req && !ext_req && m_phase == 0) break;
            step();
        end
        check("drain", {30'd0, cpu_req, ext_req}, 32'd0);
    endtask

    int                t_port [$];
    logic [DATA_W-1:0] t_rd   [$];
    int                t_cyc  [$];
    logic [DATA_W-1:0] wr_data [4];
    int                k, ext_seen, ext_before, n;
    logic [DATA_W-1:0] cpu_rd;
    logic [1:0]        sat_exp [5];

    initial begin
        for (int i = 0; i < MEM_N; i++) shadow[i] = init_val(i);
        wr_data[0] = 32'd7; wr_data[1] = 32'd2; wr_data[2] = 32'd9; wr_data[3] = 32'd14;
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        mem_load = 1'b1;
        start = 1'b1;
        cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom_range(0, 15));
        cpu_wdata = $urandom;
        ext_req = 1'($urandom); ext_we = 1'($urandom); ext_addr = 16'($urandom_range(0, 15));
        ext_wdata = $urandom; ext_lock = 1'($urandom);

        // Reset held for two edges with random requests.
        step();
        step();
        check("rst_ram_en", ram_en, 32'd0);
        check("rst_acks", {cpu_ack, ext_ack}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_owner", owner, 32'd1);
        check("rst_cnts", {cpu_cnt, ext_cnt}, 32'd0);

        // Single cpu read of RAM[3].
        start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd3; ext_req = 1'b0; ext_lock = 1'b0;
        step();
        check("rd_ram_en", ram_en, 32'd1);
        check("rd_ram_addr", ram_addr, 32'd3);
        step();
        check("rd_ram_en_off", ram_en, 32'd0);
        check("rd_cpu_ack", cpu_ack, 32'd1);
        check("rd_cpu_rdata", cpu_rdata, 32'd14);
        check("rd_cpu_cnt", cpu_cnt, 32'd1);
        check("rd_ext_ack", ext_ack, 32'd0);
        cpu_req = 1'b0;
        step();

        // Tie with continuous requests from a fresh reset: cpu, ext, cpu, ext.
        start = 1'b1;
        step();
        start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd4;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'd5;
        for (int c = 0; c < 12; c++) begin
            step();
            if (cpu_ack) begin t_port.push_back(0); t_rd.push_back(cpu_rdata); t_cyc.push_back(c); end
            if (ext_ack) begin t_port.push_back(1); t_rd.push_back(ext_rdata); t_cyc.push_back(c); end
        end
        check("rr_ack_count", t_port.size(), 32'd4);
        for (int i = 0; i < 4 && i < t_port.size(); i++) begin
            check("rr_port", t_port[i], i % 2);
            check("rr_rdata", t_rd[i], (i % 2) ? 32'd23 : 32'd45);
            if (i > 0) check("rr_spacing", t_cyc[i] - t_cyc[i-1], 32'd3);
        end
        drain();

        // Locked ext write burst to 0..3 while cpu waits to read address 2.
        k = 0; ext_seen = 0; ext_before = -1; cpu_rd = '0;
        ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 16'd0; ext_wdata = wr_data[0];
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd2;
        for (int i = 0; i < 40 && cpu_req; i++) begin
            step();
            if (ext_ack) ext_seen++;
            if (cpu_ack && ext_before < 0) begin ext_before = ext_seen; cpu_rd = cpu_rdata; end
            if (m_ack[1]) begin
                k++;
                if (k < 4) begin ext_addr = 16'(k); ext_wdata = wr_data[k]; end
                else begin ext_req = 1'b0; ext_lock = 1'b0; end
            end
            if (m_ack[0]) cpu_req = 1'b0;
        end
        check("lock_ext_acks_first", ext_before, 32'd4);
        check("lock_cpu_rdata", cpu_rd, 32'd9);
        drain();

        // Reset landing on the ACCESS cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd4;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("midrst_ack", cpu_ack, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_ram_en", ram_en, 32'd0);
        check("midrst_cnt", cpu_cnt, 32'd0);
        cpu_rd = '0;
        for (int i = 0; i < 10 && cpu_req; i++) begin
            step();
            if (cpu_ack) cpu_rd = cpu_rdata;
            if (m_ack[0]) cpu_req = 1'b0;
        end
        check("midrst_next_rdata", cpu_rd, 32'd45);
        drain();

        // Counter saturation at CNT_W=2.
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd3;
        for (int i = 0; i < 30 && n < 5; i++) begin
            step();
            if (m_ack[0]) begin
                check("sat_cpu_cnt", cpu_cnt, sat_exp[n]);
                check("sat_ext_cnt", ext_cnt, 32'd0);
                n++;
                if (n == 5) cpu_req = 1'b0;
            end
        end
        check("sat_access_count", n, 32'd5);
        drain();

        // Randomized requesters obeying the hold-until-ack rule, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 299) == 0);
            if ((cpu_req && m_ack[0]) || (!cpu_req && $urandom_range(0, 2) == 0)) begin
                cpu_req   = (cpu_req && m_ack[0]) ? 1'($urandom) : 1'b1;
                cpu_we    = 1'($urandom);
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if ((ext_req && m_ack[1]) || (!ext_req && $urandom_range(0, 2) == 0)) begin
                ext_req   = (ext_req && m_ack[1]) ? 1'($urandom) : 1'b1;
                ext_we    = 1'($urandom);
                ext_addr  = 16'($urandom_range(0, 15));
                ext_wdata = $urandom;
                ext_lock  = ($urandom_range(0, 2) != 0);
            end else if (!ext_req) begin
                ext_lock = 1'($urandom);
            end
            step();
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
